// File: rtl/arb_txn_engine.sv
// arb_txn_engine
//   Transaction engine behind a 4-agent round-robin arbiter. Takes the one-hot
//   grant, latches the owner's burst command (base address, length, direction)
//   and plays it beat by beat onto a single valid/ready memory port. Read data
//   is returned to the owner with a one-cycle agent_rvalid strobe. When the
//   burst finishes, the owner's end_transaction pulses for one cycle, and the
//   engine waits for the arbiter to drop all grants.
//
//   Optional build macro: ARB_TXN_TIMEOUT_EN adds a per-beat stall limit of
//   TIMEOUT_CYC cycles. When the limit is hit, the burst is abandoned with err
//   set and end_transaction still pulsed.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   grant0..grant3           one-hot grant from the arbiter
//   agent_addr/len/we/wdata  packed per-agent command fields, agent N at slice N
//   end_transaction0..3      one-cycle burst-complete pulse per agent
//   agent_beat               current beat index (0 in IDLE)
//   agent_rvalid/agent_rdata read data return, one-hot valid strobe
//   mem_valid/ready/we/addr/wdata  command channel to memory
//   mem_rvalid/mem_rdata     in-order read response from memory
//   busy                     engine is not idle
//   err                      sticky protocol-error flag
module arb_txn_engine #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned LEN_W       = 4,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  grant0,
   input  logic                  grant1,
   input  logic                  grant2,
   input  logic                  grant3,
   input  logic [4*ADDR_W-1:0]   agent_addr,
   input  logic [4*LEN_W-1:0]    agent_len,
   input  logic [3:0]            agent_we,
   input  logic [4*DATA_W-1:0]   agent_wdata,
   output logic                  end_transaction0,
   output logic                  end_transaction1,
   output logic                  end_transaction2,
   output logic                  end_transaction3,
   output logic [LEN_W-1:0]      agent_beat,
   output logic [3:0]            agent_rvalid,
   output logic [DATA_W-1:0]     agent_rdata,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_DONE, S_DRAIN} state_t;

   state_t              state, state_d;
   logic [1:0]          owner, owner_d;
   logic [ADDR_W-1:0]   base, base_d;
   logic [LEN_W-1:0]    len, len_d;
   logic                we, we_d;
   logic [LEN_W-1:0]    beat_d, beat_nxt;
   logic                mem_valid_d, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_d;
   logic [3:0]          agent_rvalid_d;
   logic [DATA_W-1:0]   agent_rdata_d;
   logic [3:0]          end_q, end_d;
   logic                err_d;

   logic [3:0]          grants;
   logic [1:0]          grant_idx, wdata_idx;
   logic                grant_multi;
   logic                accept;
   logic                timeout_hit;
   logic [ADDR_W-1:0]   sel_addr;
   logic [LEN_W-1:0]    sel_len;
   logic                sel_we;
   logic [DATA_W-1:0]   sel_wdata;

   assign grants      = {grant3, grant2, grant1, grant0};
   assign grant_multi = (grants & (grants - 4'd1)) != 4'd0;
   assign accept      = mem_valid && mem_ready;
   assign beat_nxt    = agent_beat + 1'b1;
   // In IDLE the owner register is not yet loaded, so write data for the
   // first beat comes from the incoming grant.
   assign wdata_idx   = (state == S_IDLE) ? grant_idx : owner;

   assign end_transaction0 = end_q[0];
   assign end_transaction1 = end_q[1];
   assign end_transaction2 = end_q[2];
   assign end_transaction3 = end_q[3];

   always_comb begin
      grant_idx = '0;
      sel_addr  = '0;
      sel_len   = '0;
      sel_we    = 1'b0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < 4; i++)
         if (grants[i]) grant_idx = 2'(i);
      for (int unsigned i = 0; i < 4; i++) begin
         if (2'(i) == grant_idx) begin
            sel_addr = agent_addr[i*ADDR_W +: ADDR_W];
            sel_len  = agent_len[i*LEN_W +: LEN_W];
            sel_we   = agent_we[i];
         end
         if (2'(i) == wdata_idx)
            sel_wdata = agent_wdata[i*DATA_W +: DATA_W];
      end
   end

`ifdef ARB_TXN_TIMEOUT_EN
   localparam int unsigned STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [STALL_W-1:0] stall_cnt;
   logic               stalled;

   assign stalled     = ((state == S_ISSUE) && !accept) ||
                        ((state == S_WAIT_RSP) && !mem_rvalid);
   assign timeout_hit = stalled && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stalled && !timeout_hit)
         stall_cnt <= stall_cnt + 1'b1;
      else
         stall_cnt <= '0;
   end
`else
   // No stall limit in this build; TIMEOUT_CYC is kept only so both builds
   // share one parameter list.
   assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

   always_comb begin
      state_d        = state;
      owner_d        = owner;
      base_d         = base;
      len_d          = len;
      we_d           = we;
      beat_d         = agent_beat;
      mem_valid_d    = mem_valid;
      mem_we_d       = mem_we;
      mem_addr_d     = mem_addr;
      mem_wdata_d    = mem_wdata;
      agent_rvalid_d = '0;
      agent_rdata_d  = agent_rdata;
      end_d          = '0;
      err_d          = err;

      if (mem_rvalid && (state != S_WAIT_RSP))
         err_d = 1'b1;
      if (((state == S_ISSUE) || (state == S_WAIT_RSP)) && !grants[owner])
         err_d = 1'b1;

      unique case (state)
         S_IDLE: begin
            if (grant_multi) begin
               err_d = 1'b1;
            end else if (grants != 4'd0) begin
               owner_d     = grant_idx;
               base_d      = sel_addr;
               len_d       = sel_len;
               we_d        = sel_we;
               beat_d      = '0;
               state_d     = S_ISSUE;
               mem_valid_d = 1'b1;
               mem_we_d    = sel_we;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
            end
         end
         S_ISSUE: begin
            if (timeout_hit) begin
               err_d        = 1'b1;
               mem_valid_d  = 1'b0;
               end_d[owner] = 1'b1;
               state_d      = S_DONE;
            end else if (accept) begin
               if (!we) begin
                  mem_valid_d = 1'b0;
                  state_d     = S_WAIT_RSP;
               end else if (agent_beat == len) begin
                  mem_valid_d  = 1'b0;
                  end_d[owner] = 1'b1;
                  state_d      = S_DONE;
               end else begin
                  beat_d      = beat_nxt;
                  mem_addr_d  = base + ADDR_W'(beat_nxt);
                  mem_wdata_d = sel_wdata;
               end
            end
         end
         S_WAIT_RSP: begin
            if (timeout_hit) begin
               err_d        = 1'b1;
               end_d[owner] = 1'b1;
               state_d      = S_DONE;
            end else if (mem_rvalid) begin
               agent_rdata_d         = mem_rdata;
               agent_rvalid_d[owner] = 1'b1;
               if (agent_beat == len) begin
                  end_d[owner] = 1'b1;
                  state_d      = S_DONE;
               end else begin
                  beat_d      = beat_nxt;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = base + ADDR_W'(beat_nxt);
                  mem_wdata_d = sel_wdata;
                  state_d     = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (grants == 4'd0) begin
               beat_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         owner        <= '0;
         base         <= '0;
         len          <= '0;
         we           <= 1'b0;
         agent_beat   <= '0;
         mem_valid    <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         agent_rvalid <= '0;
         agent_rdata  <= '0;
         end_q        <= '0;
         err          <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_d;
         owner        <= owner_d;
         base         <= base_d;
         len          <= len_d;
         we           <= we_d;
         agent_beat   <= beat_d;
         mem_valid    <= mem_valid_d;
         mem_we       <= mem_we_d;
         mem_addr     <= mem_addr_d;
         mem_wdata    <= mem_wdata_d;
         agent_rvalid <= agent_rvalid_d;
         agent_rdata  <= agent_rdata_d;
         end_q        <= end_d;
         err          <= err_d;
         busy         <= (state_d != S_IDLE);
      end
   end

endmodule
